pipe_ctrl: RTL and testbench

//  Pipeline sequencer and hazard controller for the 4-phase, 3-stage CPU (ir -> ir1 -> ir2).

---
 rtl/pipe_ctrl_pkg.sv | 61 ++++++
 rtl/pipe_ctrl_hazard_det.sv | 42 ++++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 4-phase, 3-stage pipeline controller:
// instruction classes, opcode fields, phase encodings and small decode helpers.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH0     = 4'b0001;
    localparam logic [3:0] PH1     = 4'b0010;
    localparam logic [3:0] PH2     = 4'b0100;
    localparam logic [3:0] PH3     = 4'b1000;

    localparam logic [15:0] NOP = 16'h0000;

    // Instruction field positions
    localparam int CLS_MSB  = 15;
    localparam int CLS_LSB  = 14;
    localparam int DST_MSB  = 13;
    localparam int DST_LSB  = 11;
    localparam int SRC1_MSB = 10;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 5;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LI  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;

    // ALU-class function codes live in x[4:0]; LD additionally needs x[7:5]=000
    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [4:0] OP_ST  = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_CMP = 5'b00100;
    localparam logic [4:0] OP_MLT = 5'b00101;

    // LI is class 01 with x[10:8]=000; branches are class 10 with condition in x[13:11]
    localparam logic [2:0] OP_LI  = 3'b000;
    localparam logic [2:0] OP_B   = 3'b000;
    localparam logic [2:0] OP_BZ  = 3'b001;
    localparam logic [2:0] OP_BNZ = 3'b010;

    function automatic logic is_arith(input logic [4:0] fn);
        return (fn == OP_ADD) || (fn == OP_CMP) || (fn == OP_MLT);
    endfunction

    function automatic logic alu_writes(input logic [7:0] lo);
        return (lo == OP_LD) || is_arith(lo[4:0]);
    endfunction

    function automatic logic alu_reads_a(input logic [7:0] lo);
        return (lo == OP_LD) || is_arith(lo[4:0]) || (lo[4:0] == OP_ST);
    endfunction

    function automatic logic alu_reads_b(input logic [4:0] fn);
        return is_arith(fn) || (fn == OP_ST);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational decode for the pipeline controller: load-use hazard between
// ir1 (execute) and ir (decode), and writeback-to-execute forwarding selects.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] ir1,
    input  logic [15:0] ir2,
    output logic        hazard,
    output logic        fwd_a,
    output logic        fwd_b
);

    logic ir1_is_ld;
    logic ir1_writes;
    logic ir2_writes;
    logic ir_reads_a;
    logic ir_reads_b;
    logic unused_ir_dst;

    assign ir1_is_ld  = (ir1[CLS_MSB:CLS_LSB] == CLS_ALU) && (ir1[7:0] == OP_LD);

    assign ir1_writes = ((ir1[CLS_MSB:CLS_LSB] == CLS_ALU) && alu_writes(ir1[7:0])) ||
                        ((ir1[CLS_MSB:CLS_LSB] == CLS_LI)  && (ir1[SRC1_MSB:SRC1_LSB] == OP_LI));

    assign ir2_writes = ((ir2[CLS_MSB:CLS_LSB] == CLS_ALU) && alu_writes(ir2[7:0])) ||
                        ((ir2[CLS_MSB:CLS_LSB] == CLS_LI)  && (ir2[SRC1_MSB:SRC1_LSB] == OP_LI));

    assign ir_reads_a = (ir[CLS_MSB:CLS_LSB] == CLS_ALU) && alu_reads_a(ir[7:0]);
    assign ir_reads_b = (ir[CLS_MSB:CLS_LSB] == CLS_ALU) && alu_reads_b(ir[4:0]);

    // The decode-stage destination plays no part in hazard detection
    assign unused_ir_dst = ^ir[DST_MSB:DST_LSB];

    assign hazard = ir1_is_ld && ir1_writes &&
                    ((ir_reads_a && (ir[SRC1_MSB:SRC1_LSB] == ir1[DST_MSB:DST_LSB])) ||
                     (ir_reads_b && (ir[SRC2_MSB:SRC2_LSB] == ir1[DST_MSB:DST_LSB])));

    assign fwd_a = ir2_writes && (ir2[DST_MSB:DST_LSB] == ir1[SRC1_MSB:SRC1_LSB]);
    assign fwd_b = ir2_writes && (ir2[DST_MSB:DST_LSB] == ir1[SRC2_MSB:SRC2_LSB]);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: one-hot phase FSM, stall/flush injection and stage-load strobes.
// Optional saturating performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | halted, ph=0000, no strobes; pending stall/flush retained
//   ST_RUN  | ph rotates 0001->0010->0100->1000 each cycle, one round = 4 cycles
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      ir,
    input  logic [15:0]      ir1,
    input  logic [15:0]      ir2,
    input  logic             br_taken,
    output logic [3:0]       ph,
    output logic             pc_inc,
    output logic             ir_ld,
    output logic             ir1_ld,
    output logic             ir1_nop,
    output logic             ir2_ld,
    output logic             ir2_nop,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             busy,
    output logic [CNT_W-1:0] perf_rounds,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    state_t state;
    logic   stall_q;
    logic   flush_q;
    logic   stop_pend;
    logic   hazard;
    logic   fwd_a_raw;
    logic   fwd_b_raw;
    logic   running;

    pipe_hazard_det u_hazard (
        .ir     (ir),
        .ir1    (ir1),
        .ir2    (ir2),
        .hazard (hazard),
        .fwd_a  (fwd_a_raw),
        .fwd_b  (fwd_b_raw)
    );

    // Stall/flush decisions are taken at the end of every round, including the
    // one that stops, so a pending bubble or flush survives an IDLE period.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            ph        <= PH_IDLE;
            stall_q   <= 1'b0;
            flush_q   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ph <= PH_IDLE;
                    if (start && !stop) begin
                        state <= ST_RUN;
                        ph    <= PH0;
                    end
                end
                ST_RUN: begin
                    if (ph[3]) begin
                        flush_q <= br_taken;
                        stall_q <= !br_taken && !stall_q && hazard;
                        if (stop_pend || stop) begin
                            state     <= ST_IDLE;
                            ph        <= PH_IDLE;
                            stop_pend <= 1'b0;
                        end else begin
                            ph <= PH0;
                        end
                    end else begin
                        ph        <= {ph[2:0], 1'b0};
                        stop_pend <= stop_pend || stop;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ph    <= PH_IDLE;
                end
            endcase
        end
    end

    assign running = (state == ST_RUN);
    assign busy    = running;

    // ph is 0000 in IDLE, so every strobe is naturally quiet there
    assign pc_inc  = ph[0] && !stall_q;
    assign ir_ld   = ph[0] && !stall_q;
    assign ir1_ld  = ph[1];
    assign ir1_nop = ph[1] && (stall_q || flush_q);
    assign ir2_ld  = ph[2];
    assign ir2_nop = ph[2] && flush_q;

    assign fwd_a   = running && fwd_a_raw;
    assign fwd_b   = running && fwd_b_raw;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] rounds_q;
    logic [CNT_W-1:0] stalls_q;
    logic [CNT_W-1:0] flushes_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rounds_q  <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            if (running && ph[3] && !(&rounds_q))
                rounds_q <= rounds_q + CNT_W'(1);
            if (ph[1] && stall_q && !flush_q && !(&stalls_q))
                stalls_q <= stalls_q + CNT_W'(1);
            if (ph[1] && flush_q && !(&flushes_q))
                flushes_q <= flushes_q + CNT_W'(1);
        end
    end

    assign perf_rounds  = rounds_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`else
    assign perf_rounds  = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: phase sequencing, stop, load-use bubble,
// branch flush, forwarding selects and asynchronous reset.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start, stop, br_taken;
    logic [15:0] ir, ir1, ir2;
    logic [3:0]  ph;
    logic        pc_inc, ir_ld, ir1_ld, ir1_nop, ir2_ld, ir2_nop;
    logic        fwd_a, fwd_b, busy;
    logic [15:0] perf_rounds, perf_stalls, perf_flushes;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [15:0] I_LD_R3    = 16'h1901; // LD r3,(r1)
    localparam logic [15:0] I_ADD_USE3 = 16'h2342; // ADD r4,r3,r2
    localparam logic [15:0] I_ADD_R5   = 16'h2802; // ADD r5,...
    localparam logic [15:0] I_ADD_A5   = 16'h0D42; // ADD r1,r5,r2
    localparam logic [15:0] I_ADD_B5   = 16'h0AA2; // ADD r1,r2,r5
    localparam logic [15:0] I_LI_R5    = 16'h6800; // LI r5,#0
    localparam logic [15:0] I_ST_5     = 16'h2803; // ST, dst field 5, no write

    pipe_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .stop(stop),
        .ir(ir), .ir1(ir1), .ir2(ir2), .br_taken(br_taken),
        .ph(ph), .pc_inc(pc_inc), .ir_ld(ir_ld), .ir1_ld(ir1_ld), .ir1_nop(ir1_nop),
        .ir2_ld(ir2_ld), .ir2_nop(ir2_nop), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy),
        .perf_rounds(perf_rounds), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RSTN = 1'b0; start = 1'b0; stop = 1'b0; br_taken = 1'b0;
        ir = '0; ir1 = '0; ir2 = '0;
        #12;
        check("rst_ph", ph, 4'b0000);
        check("rst_busy", busy, 0);
        check("rst_pc_inc", pc_inc, 0);
        check("rst_perf_rounds", perf_rounds, 0);
        cyc();
        RSTN = 1'b1;
        cyc();
        check("idle_ph", ph, 4'b0000);

        // T1: start and phase rotation
        start = 1'b1;
        cyc(); start = 1'b0;
        check("t1_ph0", ph, 4'b0001);
        check("t1_pc_inc0", pc_inc, 1);
        check("t1_ir_ld0", ir_ld, 1);
        check("t1_busy", busy, 1);
        cyc();
        check("t1_ph1", ph, 4'b0010);
        check("t1_pc_inc1", pc_inc, 0);
        check("t1_ir1_ld", ir1_ld, 1);
        cyc();
        check("t1_ph2", ph, 4'b0100);
        check("t1_ir2_ld", ir2_ld, 1);
        cyc();
        check("t1_ph3", ph, 4'b1000);
        cyc();
        check("t1_ph0b", ph, 4'b0001);
        check("t1_pc_inc0b", pc_inc, 1);

        // T2: stop pulsed at ph=0010 finishes the round then idles
        cyc();
        check("t2_ph1", ph, 4'b0010);
        stop = 1'b1;
        cyc(); stop = 1'b0;
        check("t2_ph2", ph, 4'b0100);
        cyc();
        check("t2_ph3", ph, 4'b1000);
        check("t2_busy_ph3", busy, 1);
        cyc();
        check("t2_idle_ph", ph, 4'b0000);
        check("t2_idle_busy", busy, 0);
        cyc();
        check("t2_idle_pc_inc", pc_inc, 0);
        check("t2_idle_ph2", ph, 4'b0000);

        // T3: load-use bubble; ir1 stays LD through the stall round to prove a single bubble
        start = 1'b1;
        cyc(); start = 1'b0;
        ir1 = I_LD_R3; ir = I_ADD_USE3;
        cyc(); cyc(); cyc();
        check("t3_ph3", ph, 4'b1000);
        cyc();
        check("t3_stall_pc_inc", pc_inc, 0);
        check("t3_stall_ir_ld", ir_ld, 0);
        cyc();
        check("t3_stall_ir1_nop", ir1_nop, 1);
        check("t3_stall_ir1_ld", ir1_ld, 1);
        cyc();
        check("t3_stall_ir2_nop", ir2_nop, 0);
        cyc();
        cyc();
        check("t3_next_pc_inc", pc_inc, 1);
        ir1 = '0; ir = '0;
        cyc();
        check("t3_next_ir1_nop", ir1_nop, 0);
        check("t3_perf_stalls", perf_stalls, PERF ? 1 : 0);
        cyc();
        cyc();
        check("t4_ph3", ph, 4'b1000);

        // T4: branch flush with a simultaneous hazard
        br_taken = 1'b1; ir1 = I_LD_R3; ir = I_ADD_USE3;
        cyc();
        br_taken = 1'b0; ir1 = '0; ir = '0;
        check("t4_flush_pc_inc", pc_inc, 1);
        cyc();
        check("t4_ir1_nop", ir1_nop, 1);
        cyc();
        check("t4_ir2_nop", ir2_nop, 1);
        check("t4_ir1_nop_ph2", ir1_nop, 0);
        cyc();
        check("t4_ir2_nop_ph3", ir2_nop, 0);
        cyc();
        check("t4_after_pc_inc", pc_inc, 1);
        cyc();
        check("t4_no_bubble", ir1_nop, 0);
        check("t4_perf_flushes", perf_flushes, PERF ? 1 : 0);
        check("t4_perf_stalls", perf_stalls, PERF ? 1 : 0);
        check("t4_perf_rounds", perf_rounds, PERF ? 6 : 0);

        // T5: forwarding selects (combinational)
        ir2 = I_ADD_R5; ir1 = I_ADD_A5; #1;
        check("t5_add_fwd_a", fwd_a, 1);
        check("t5_add_fwd_b", fwd_b, 0);
        ir1 = I_ADD_B5; #1;
        check("t5_b_fwd_a", fwd_a, 0);
        check("t5_b_fwd_b", fwd_b, 1);
        ir2 = I_LI_R5; ir1 = I_ADD_A5; #1;
        check("t5_li_fwd_a", fwd_a, 1);
        ir2 = I_ST_5; #1;
        check("t5_st_fwd_a", fwd_a, 0);
        check("t5_st_fwd_b", fwd_b, 0);
        ir2 = '0; ir1 = '0;

        // T6: async reset mid-round, then start&stop together
        cyc();
        check("t6_ph2", ph, 4'b0100);
        RSTN = 1'b0; #1;
        check("t6_rst_ph", ph, 4'b0000);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_perf_rounds", perf_rounds, 0);
        cyc();
        RSTN = 1'b1;
        start = 1'b1; stop = 1'b1;
        cyc();
        check("t6_startstop_ph", ph, 4'b0000);
        check("t6_startstop_busy", busy, 0);
        stop = 1'b0;
        cyc(); start = 1'b0;
        check("t6_restart_ph", ph, 4'b0001);

        // T7: stall pending across stop/restart
        ir1 = I_LD_R3; ir = I_ADD_USE3;
        cyc(); cyc(); cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0; ir1 = '0; ir = '0;
        check("t7_idle_ph", ph, 4'b0000);
        cyc();
        start = 1'b1;
        cyc(); start = 1'b0;
        check("t7_restart_ph", ph, 4'b0001);
        check("t7_held_stall_pc_inc", pc_inc, 0);
        cyc();
        check("t7_held_stall_ir1_nop", ir1_nop, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
